// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator sequencing controller.
package calc_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [2:0] {
        S_ENT_A,
        S_ENT_B,
        S_START,
        S_WAIT,
        S_SHOW
    } estado_t;

endpackage

// File: rtl/boton_flanco.sv
// Rising-edge detector for one button. History resets to 1 so that a
// button already held while reset is released does not produce an event.
module boton_flanco (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic flanco_o
);

    logic btn_q;

    // Remember last sampled level of the button.
    always_ff @(posedge clk) begin
        if (rst) btn_q <= 1'b1;
        else     btn_q <= btn_i;
    end

    assign flanco_o = btn_i & ~btn_q;

endmodule

// File: rtl/control_calculadora.sv
// Sequencing controller for digit entry, operand capture and the external
// BCD adder handshake. Optional adder timeout is built when the macro
// CONTROL_CALC_TIMEOUT_EN is defined (adds the err_timeout output).
//
// state   | meaning
// S_ENT_A | entering first operand
// S_ENT_B | entering second operand
// S_START | suma_start high for this single cycle
// S_WAIT  | waiting for suma_done from the adder
// S_SHOW  | result displayed until finalizar
module control_calculadora
    import calc_pkg::*;
#(
    parameter int NUM_DIGITS = 3
`ifdef CONTROL_CALC_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 16
`endif
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              push,
    input  logic                              guardar,
    input  logic                              finalizar,
    input  logic [DIGIT_W-1:0]                entrada,
    input  logic                              suma_done,
    input  logic [DIGIT_W*(NUM_DIGITS+1)-1:0] suma_res,
    output logic [DIGIT_W*NUM_DIGITS-1:0]     numero,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   n_digitos,
    output logic [DIGIT_W*NUM_DIGITS-1:0]     op_a,
    output logic [DIGIT_W*NUM_DIGITS-1:0]     op_b,
    output logic                              suma_start,
    output logic [DIGIT_W*(NUM_DIGITS+1)-1:0] resultado,
    output logic                              resultado_valid,
    output logic                              rst_dat,
    output logic                              err_digito
`ifdef CONTROL_CALC_TIMEOUT_EN
    ,
    output logic                              err_timeout
`endif
);

    localparam int NDW = $clog2(NUM_DIGITS + 1);
    localparam int NW  = DIGIT_W * NUM_DIGITS;
    localparam int RW  = DIGIT_W * (NUM_DIGITS + 1);
    localparam logic [NDW-1:0] N_MAX = NDW'(NUM_DIGITS);

    logic ev_push, ev_guardar, ev_fin;

    boton_flanco u_flanco_push (.clk(clk), .rst(rst), .btn_i(push),      .flanco_o(ev_push));
    boton_flanco u_flanco_guar (.clk(clk), .rst(rst), .btn_i(guardar),   .flanco_o(ev_guardar));
    boton_flanco u_flanco_fin  (.clk(clk), .rst(rst), .btn_i(finalizar), .flanco_o(ev_fin));

    estado_t         estado_q;
    logic [NW-1:0]   numero_q, op_a_q, op_b_q;
    logic [NDW-1:0]  n_digitos_q;
    logic [RW-1:0]   resultado_q;
    logic            suma_start_q, resultado_valid_q, rst_dat_q, err_digito_q;

`ifdef CONTROL_CALC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt_q;
    logic          err_timeout_q;
    assign err_timeout = err_timeout_q;
`endif

    // Main controller: state, datapath registers and registered pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q          <= S_ENT_A;
            numero_q          <= '0;
            n_digitos_q       <= '0;
            op_a_q            <= '0;
            op_b_q            <= '0;
            resultado_q       <= '0;
            suma_start_q      <= 1'b0;
            resultado_valid_q <= 1'b0;
            rst_dat_q         <= 1'b0;
            err_digito_q      <= 1'b0;
`ifdef CONTROL_CALC_TIMEOUT_EN
            tmo_cnt_q         <= '0;
            err_timeout_q     <= 1'b0;
`endif
        end else begin
            rst_dat_q    <= 1'b0;
            err_digito_q <= 1'b0;
            suma_start_q <= 1'b0;
            if (ev_fin) begin
                estado_q          <= S_ENT_A;
                numero_q          <= '0;
                n_digitos_q       <= '0;
                op_a_q            <= '0;
                op_b_q            <= '0;
                resultado_q       <= '0;
                resultado_valid_q <= 1'b0;
                rst_dat_q         <= 1'b1;
`ifdef CONTROL_CALC_TIMEOUT_EN
                err_timeout_q     <= 1'b0;
`endif
            end else begin
                case (estado_q)
                    S_ENT_A, S_ENT_B: begin
                        if (ev_guardar) begin
                            if (estado_q == S_ENT_A) begin
                                op_a_q   <= numero_q;
                                estado_q <= S_ENT_B;
                            end else begin
                                op_b_q       <= numero_q;
                                estado_q     <= S_START;
                                suma_start_q <= 1'b1;
                            end
                            numero_q    <= '0;
                            n_digitos_q <= '0;
                            rst_dat_q   <= 1'b1;
                        end else if (ev_push) begin
                            // An invalid digit is flagged even when the entry is full.
                            if (entrada > BCD_MAX) begin
                                err_digito_q <= 1'b1;
                            end else if (n_digitos_q < N_MAX) begin
                                numero_q    <= {numero_q[NW-DIGIT_W-1:0], entrada};
                                n_digitos_q <= n_digitos_q + NDW'(1);
                            end
                        end
                    end
                    S_START: begin
                        estado_q <= S_WAIT;
`ifdef CONTROL_CALC_TIMEOUT_EN
                        tmo_cnt_q <= TW'(TIMEOUT_CYC - 1);
`endif
                    end
                    S_WAIT: begin
                        if (suma_done) begin
                            resultado_q       <= suma_res;
                            resultado_valid_q <= 1'b1;
                            estado_q          <= S_SHOW;
                        end
`ifdef CONTROL_CALC_TIMEOUT_EN
                        else if (tmo_cnt_q == '0) begin
                            resultado_q       <= '0;
                            resultado_valid_q <= 1'b1;
                            err_timeout_q     <= 1'b1;
                            estado_q          <= S_SHOW;
                        end else begin
                            tmo_cnt_q <= tmo_cnt_q - TW'(1);
                        end
`endif
                    end
                    S_SHOW: begin
                        // Only finalizar leaves this state.
                    end
                    default: estado_q <= S_ENT_A;
                endcase
            end
        end
    end

    assign numero          = numero_q;
    assign n_digitos       = n_digitos_q;
    assign op_a            = op_a_q;
    assign op_b            = op_b_q;
    assign suma_start      = suma_start_q;
    assign resultado       = resultado_q;
    assign resultado_valid = resultado_valid_q;
    assign rst_dat         = rst_dat_q;
    assign err_digito      = err_digito_q;

endmodule

// File: tb/tb_control_calculadora.sv
// Directed bench for control_calculadora with hand-computed expectations.
// The timeout scenario runs when CONTROL_CALC_TIMEOUT_EN is defined.
module tb_control_calculadora;

    logic        clk = 1'b0;
    logic        rst, push, guardar, finalizar, suma_done;
    logic [3:0]  entrada;
    logic [15:0] suma_res;
    logic [11:0] numero, op_a, op_b;
    logic [1:0]  n_digitos;
    logic        suma_start, resultado_valid, rst_dat, err_digito;
    logic [15:0] resultado;
`ifdef CONTROL_CALC_TIMEOUT_EN
    logic        err_timeout;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    control_calculadora dut (
        .clk(clk), .rst(rst), .push(push), .guardar(guardar), .finalizar(finalizar),
        .entrada(entrada), .suma_done(suma_done), .suma_res(suma_res),
        .numero(numero), .n_digitos(n_digitos), .op_a(op_a), .op_b(op_b),
        .suma_start(suma_start), .resultado(resultado), .resultado_valid(resultado_valid),
        .rst_dat(rst_dat), .err_digito(err_digito)
`ifdef CONTROL_CALC_TIMEOUT_EN
        , .err_timeout(err_timeout)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_d(input logic [3:0] d);
        entrada = d; push = 1'b1; tick(); push = 1'b0; tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".numero"}, numero, 0);
        chk({tag, ".n_dig"}, n_digitos, 0);
        chk({tag, ".op_a"}, op_a, 0);
        chk({tag, ".op_b"}, op_b, 0);
        chk({tag, ".resultado"}, resultado, 0);
        chk({tag, ".valid"}, resultado_valid, 0);
        chk({tag, ".start"}, suma_start, 0);
        chk({tag, ".err_dig"}, err_digito, 0);
    endtask

    initial begin
        rst = 1'b1; push = 1'b1; guardar = 1'b0; finalizar = 1'b0;
        entrada = 4'd5; suma_done = 1'b0; suma_res = '0;
        tick(); tick();
        chk_all_zero("reset");
        chk("reset.rst_dat", rst_dat, 0);
        // push held through reset must not register a digit
        rst = 1'b0; tick(); tick();
        chk("held_at_reset.numero", numero, 0);
        push = 1'b0; tick();

        // digit entry and saturation
        push_d(4'd3); push_d(4'd5); push_d(4'd7);
        chk("entry.numero", numero, 12'h357);
        chk("entry.n_dig", n_digitos, 3);
        entrada = 4'd8; push = 1'b1; tick();
        chk("sat.err_dig", err_digito, 0);
        chk("sat.numero", numero, 12'h357);
        push = 1'b0; tick();
        chk("sat.n_dig", n_digitos, 3);

        // operand A
        guardar = 1'b1; tick();
        chk("gA.rst_dat", rst_dat, 1);
        chk("gA.op_a", op_a, 12'h357);
        chk("gA.numero", numero, 0);
        chk("gA.n_dig", n_digitos, 0);
        guardar = 1'b0; tick();
        chk("gA.rst_dat_off", rst_dat, 0);

        // operand B and adder handshake
        push_d(4'd4); push_d(4'd2); push_d(4'd1);
        guardar = 1'b1; tick();
        chk("gB.op_b", op_b, 12'h421);
        chk("gB.rst_dat", rst_dat, 1);
        chk("start.pulse", suma_start, 1);
        guardar = 1'b0; tick();
        chk("start.off", suma_start, 0);
        chk("gB.rst_dat_off", rst_dat, 0);
        tick();
        chk("wait.start_off", suma_start, 0);
        chk("wait.valid", resultado_valid, 0);
        suma_done = 1'b1; suma_res = 16'h0778; tick();
        suma_done = 1'b0; suma_res = 16'h0;
        chk("sum.resultado", resultado, 16'h0778);
        chk("sum.valid", resultado_valid, 1);

        // push and guardar ignored while showing
        push_d(4'd5);
        chk("show.numero", numero, 0);
        guardar = 1'b1; tick(); guardar = 1'b0; tick();
        chk("show.op_a", op_a, 12'h357);
        chk("show.valid", resultado_valid, 1);
        finalizar = 1'b1; tick();
        chk_all_zero("fin");
        chk("fin.rst_dat", rst_dat, 1);
        finalizar = 1'b0; tick();

        // priority guardar over push
        push_d(4'd1); push_d(4'd2);
        chk("prio.pre", numero, 12'h012);
        entrada = 4'd6; push = 1'b1; guardar = 1'b1; tick();
        chk("prio.op_a", op_a, 12'h012);
        chk("prio.numero", numero, 0);
        chk("prio.n_dig", n_digitos, 0);
        push = 1'b0; guardar = 1'b0; tick();

        // invalid digit, then held push
        entrada = 4'hC; push = 1'b1; tick();
        chk("bad.err_dig", err_digito, 1);
        chk("bad.numero", numero, 0);
        push = 1'b0; tick();
        chk("bad.err_off", err_digito, 0);
        entrada = 4'd2; push = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        push = 1'b0; tick();
        chk("held.numero", numero, 12'h002);
        chk("held.n_dig", n_digitos, 1);

        // finalizar beats guardar, returns to S_ENT_A
        finalizar = 1'b1; guardar = 1'b1; tick();
        chk_all_zero("fin_prio");
        finalizar = 1'b0; guardar = 1'b0; tick();
        push_d(4'd9);
        guardar = 1'b1; tick(); guardar = 1'b0; tick();
        chk("fin_prio.state_a", op_a, 12'h009);
        chk("fin_prio.op_b", op_b, 0);

        // reset in S_WAIT, late suma_done ignored
        push_d(4'd7);
        guardar = 1'b1; tick(); guardar = 1'b0; tick();
        chk("rw.op_b", op_b, 12'h007);
        rst = 1'b1; tick(); rst = 1'b0;
        chk_all_zero("rst_wait");
        tick(); tick();
        suma_done = 1'b1; suma_res = 16'h0999; tick();
        suma_done = 1'b0;
        tick();
        chk("late.resultado", resultado, 0);
        chk("late.valid", resultado_valid, 0);

`ifdef CONTROL_CALC_TIMEOUT_EN
        // empty operands, then no suma_done
        guardar = 1'b1; tick(); guardar = 1'b0; tick();
        chk("tmo.op_a_zero", op_a, 0);
        guardar = 1'b1; tick(); guardar = 1'b0; tick();
        for (int i = 0; i < 15; i++) tick();
        chk("tmo.pre_valid", resultado_valid, 0);
        chk("tmo.pre_err", err_timeout, 0);
        tick();
        chk("tmo.valid", resultado_valid, 1);
        chk("tmo.resultado", resultado, 0);
        chk("tmo.err", err_timeout, 1);
        tick();
        chk("tmo.err_hold", err_timeout, 1);
        finalizar = 1'b1; tick(); finalizar = 1'b0;
        chk("tmo.err_clr", err_timeout, 0);
        chk("tmo.valid_clr", resultado_valid, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
